// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the multicycle hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned NREGS      = 1 << REG_W;
  localparam int unsigned EXC_REG    = 30;
  // Widest packed latency vector the helper below accepts.
  localparam int unsigned LATS_MAX_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } entry_state_e;

  // Latency of unit idx: field idx (LSB-first) of a packed array of w-bit fields.
  function automatic int unsigned lat_field(input logic [LATS_MAX_W-1:0] lats,
                                            input int unsigned           idx,
                                            input int unsigned           w);
    return 32'(lats >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue / completion handshake between the X stage, the scoreboard and the regfile write port.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned N_UNITS = 2
);
  localparam int unsigned UNIT_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic              issue_valid;
  logic [UNIT_W-1:0] issue_unit;
  logic [REG_W-1:0]  issue_rd;
  logic [N_UNITS-1:0] issue_ready;
  logic              complete_valid;
  logic [UNIT_W-1:0] complete_unit;
  logic [REG_W-1:0]  complete_rd;
  logic              wb_ack;

  modport master (
    output issue_valid, issue_unit, issue_rd, wb_ack,
    input  issue_ready, complete_valid, complete_unit, complete_rd
  );

  modport slave (
    input  issue_valid, issue_unit, issue_rd, wb_ack,
    output issue_ready, complete_valid, complete_unit, complete_rd
  );
endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One in-flight slot: IDLE -> RUN (countdown) -> DONE -> IDLE on ack.
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W = 6,
  parameter int unsigned LAT   = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_i,
  input  logic [REG_W-1:0] issue_rd_i,
  input  logic             ack_i,
  output entry_state_e     state_o,
  output logic [REG_W-1:0] rd_o
);

  localparam logic [LAT_W-1:0] CNT_LOAD = LAT_W'(LAT - 1);

  entry_state_e     state_q;
  logic [REG_W-1:0] rd_q;
  logic [LAT_W-1:0] cnt_q;

  // Entry FSM; the countdown reaching 1 marks the last RUN cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_i) begin
            state_q <= ST_RUN;
            rd_q    <= issue_rd_i;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == LAT_W'(1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (ack_i) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign rd_o    = rd_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Multicycle-unit scoreboard: per-unit entries, writeback arbitration, D-stage hazard detection.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned           N_UNITS   = 2,
  parameter int unsigned           LAT_W     = 6,
  parameter logic [N_UNITS*LAT_W-1:0] UNIT_LATS = {6'd32, 6'd16},
  parameter int unsigned           CNT_W     = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  hazard_scoreboard_if.slave  bus,
  input  logic [REG_W-1:0]    d_rs1,
  input  logic [REG_W-1:0]    d_rs2,
  input  logic [REG_W-1:0]    d_rd,
  input  logic                d_is_bex,
  input  logic                x_is_load,
  input  logic [REG_W-1:0]    x_rd,
  output logic                stall_fd,
  output logic                nop_dx,
  output logic [NREGS-1:0]    busy_mask,
  output logic                exc_pending,
  output logic [CNT_W-1:0]    stall_count
);

  localparam int unsigned UNIT_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  entry_state_e      ent_state [N_UNITS];
  logic [REG_W-1:0]  ent_rd    [N_UNITS];
  logic              issue_fire;
  logic              ack_fire;
  logic              gnt_valid;
  logic [UNIT_W-1:0] gnt_idx;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign issue_fire = bus.issue_valid && bus.issue_ready[bus.issue_unit];
  assign ack_fire   = bus.wb_ack && gnt_valid;

  for (genvar g = 0; g < N_UNITS; g++) begin : g_entry
    scoreboard_entry #(
      .LAT_W (LAT_W),
      .LAT   (lat_field(LATS_MAX_W'(UNIT_LATS), g, LAT_W))
    ) u_entry (
      .clock      (clock),
      .reset_n    (reset_n),
      .issue_i    (issue_fire && (bus.issue_unit == UNIT_W'(g))),
      .issue_rd_i (bus.issue_rd),
      .ack_i      (ack_fire && (gnt_idx == UNIT_W'(g))),
      .state_o    (ent_state[g]),
      .rd_o       (ent_rd[g])
    );
  end

  // Ready flags, busy register set and EXC_REG pending flag from entry state.
  always_comb begin
    bus.issue_ready = '0;
    busy_mask       = '0;
    exc_pending     = 1'b0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (ent_state[i] == ST_IDLE) begin
        bus.issue_ready[i] = 1'b1;
      end else begin
        if (ent_rd[i] != '0) busy_mask[ent_rd[i]] = 1'b1;
        if (ent_rd[i] == REG_W'(EXC_REG)) exc_pending = 1'b1;
      end
    end
  end

  // Fixed-priority writeback grant: scanning downward leaves the lowest DONE index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = N_UNITS; i > 0; i--) begin
      if (ent_state[i-1] == ST_DONE) begin
        gnt_valid = 1'b1;
        gnt_idx   = UNIT_W'(i - 1);
      end
    end
  end

  assign bus.complete_valid = gnt_valid;
  assign bus.complete_unit  = gnt_idx;
  assign bus.complete_rd    = gnt_valid ? ent_rd[gnt_idx] : '0;

  // RAW / WAW / load-use / bex hazards; an entry being acked still counts as busy.
  always_comb begin
    logic raw, waw, load_use, bex;
    raw      = ((d_rs1 != '0) && busy_mask[d_rs1]) || ((d_rs2 != '0) && busy_mask[d_rs2]);
    waw      = (d_rd != '0) && busy_mask[d_rd];
    load_use = x_is_load && (x_rd != '0) && ((x_rd == d_rs1) || (x_rd == d_rs2));
    bex      = d_is_bex && exc_pending;
    stall_fd = raw || waw || load_use || bex;
    nop_dx   = stall_fd;
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall_fd && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a time-based reference model.
module tb_hazard_scoreboard;

  logic        clock;
  logic        reset_n;
  logic [4:0]  d_rs1, d_rs2, d_rd, x_rd;
  logic        d_is_bex, x_is_load;
  logic        stall_fd, nop_dx, exc_pending;
  logic [31:0] busy_mask;
  logic [31:0] stall_count;

  hazard_scoreboard_if #(.N_UNITS(2)) bus ();

  // Unit 0 latency 32, unit 1 latency 16.
  hazard_scoreboard #(
    .N_UNITS   (2),
    .LAT_W     (6),
    .UNIT_LATS ({6'd16, 6'd32}),
    .CNT_W     (32)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .d_rs1       (d_rs1),
    .d_rs2       (d_rs2),
    .d_rd        (d_rd),
    .d_is_bex    (d_is_bex),
    .x_is_load   (x_is_load),
    .x_rd        (x_rd),
    .stall_fd    (stall_fd),
    .nop_dx      (nop_dx),
    .busy_mask   (busy_mask),
    .exc_pending (exc_pending),
    .stall_count (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: each unit is either free or holds (rd, cycle its result appears).
  int          LAT [2] = '{32, 16};
  bit          m_busy    [2];
  logic [4:0]  m_rd      [2];
  int          m_done_at [2];
  int          cyc;
  logic [31:0] m_stall;

  // Observations captured by the last tick, for scenario-level checks.
  logic        obs_cv, obs_stall, obs_exc;
  logic [4:0]  obs_rd;
  logic [31:0] obs_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_unit  = '0;
    bus.issue_rd    = '0;
    bus.wb_ack      = 1'b0;
    d_rs1 = '0; d_rs2 = '0; d_rd = '0; x_rd = '0;
    d_is_bex = 1'b0; x_is_load = 1'b0;
  endtask

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 1'b0; m_rd[u] = '0; m_done_at[u] = 0;
    end
    m_stall = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_issue_ready", bus.issue_ready, 2'b11);
    check("rst_busy_mask", busy_mask, 0);
    check("rst_complete_valid", bus.complete_valid, 0);
    check("rst_complete_rd", bus.complete_rd, 0);
    check("rst_exc_pending", exc_pending, 0);
    check("rst_stall_fd", stall_fd, 0);
    check("rst_nop_dx", nop_dx, 0);
    check("rst_stall_count", stall_count, 0);
  endtask

  // Evaluate one cycle: inputs are already applied; check, then advance model at the edge.
  task automatic tick();
    logic [1:0]  e_ready;
    logic        e_cv, e_exc, e_haz, fire, ack;
    int          e_cu, iu;
    logic [4:0]  ird;
    logic [31:0] pend;
    #1;
    e_ready = '0; e_cv = 1'b0; e_cu = 0; e_exc = 1'b0; pend = '0;
    for (int u = 0; u < 2; u++) begin
      if (!m_busy[u]) e_ready[u] = 1'b1;
      else begin
        if (m_rd[u] != 0) pend[m_rd[u]] = 1'b1;
        if (m_rd[u] == 5'd30) e_exc = 1'b1;
        if (!e_cv && cyc >= m_done_at[u]) begin e_cv = 1'b1; e_cu = u; end
      end
    end
    e_haz = (d_rs1 != 0 && pend[d_rs1]) || (d_rs2 != 0 && pend[d_rs2]) ||
            (d_rd != 0 && pend[d_rd]) ||
            (x_is_load && x_rd != 0 && (x_rd == d_rs1 || x_rd == d_rs2)) ||
            (d_is_bex && e_exc);
    check("issue_ready", bus.issue_ready, e_ready);
    check("complete_valid", bus.complete_valid, e_cv);
    if (e_cv) begin
      check("complete_unit", bus.complete_unit, e_cu);
      check("complete_rd", bus.complete_rd, m_rd[e_cu]);
    end
    check("busy_mask", busy_mask, pend);
    check("exc_pending", exc_pending, e_exc);
    check("stall_fd", stall_fd, e_haz);
    check("nop_dx", nop_dx, e_haz);
    check("stall_count", stall_count, m_stall);
    if (bus.issue_valid) check("issue_to_ready_unit", bus.issue_ready[bus.issue_unit], 1);
    obs_cv = bus.complete_valid; obs_rd = bus.complete_rd; obs_stall = stall_fd;
    obs_exc = exc_pending; obs_busy = busy_mask;
    fire = bus.issue_valid && e_ready[bus.issue_unit];
    iu   = int'(bus.issue_unit);
    ird  = bus.issue_rd;
    ack  = bus.wb_ack && e_cv;
    @(posedge clock);
    if (e_haz && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (ack) m_busy[e_cu] = 1'b0;
    if (fire) begin
      m_busy[iu] = 1'b1; m_rd[iu] = ird; m_done_at[iu] = cyc + LAT[iu];
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    clear_inputs();
    bus.wb_ack = 1'b1;
    n = 0;
    while ((m_busy[0] || m_busy[1]) && n < 200) begin tick(); n++; end
    if (n >= 200) check("drain_timeout", 1, 0);
    tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic mid_reset();
    #2;
    clear_inputs();
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] tbl [8] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd7, 5'd9, 5'd12, 5'd30};
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 7)];
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int n_cv, first, n_st;
    logic b16, b17, v32, v33;
    logic [4:0] r32, r33;
    logic [31:0] base;

    clear_inputs();
    model_clear();
    cyc = 0;
    reset_n = 1'b0;
    #7;
    check_reset_outputs();
    @(negedge clock);
    reset_n = 1'b1;

    // Latency: unit1 rd=7, result visible only in cycle 16, busy bit gone in 17.
    clear_inputs();
    bus.wb_ack = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_unit = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 1'b0;
    n_cv = 0; first = -1; b16 = 1'b0; b17 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (obs_cv) begin n_cv++; if (first < 0) first = k; end
      if (k == 16) b16 = obs_busy[7];
      if (k == 17) b17 = obs_busy[7];
    end
    check("lat_done_cycle", first, 16);
    check("lat_valid_cycles", n_cv, 1);
    check("lat_busy7_in_done", b16, 1);
    check("lat_busy7_cleared", b17, 0);

    // RAW: unit0 rd=9 with d_rs2=9 stalls cycles 1..32.
    clear_inputs();
    base = m_stall;
    bus.wb_ack = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_unit = 1'b0; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    d_rs2 = 5'd9;
    n_st = 0;
    for (int k = 1; k <= 40; k++) begin tick(); if (obs_stall) n_st++; end
    check("raw_stall_cycles", n_st, 32);
    check("raw_stall_count", stall_count - base, 32);
    drain();

    // Arbitration: both units DONE in the same cycle; unit0 (rd=3) first.
    clear_inputs();
    bus.wb_ack = 1'b1;
    v32 = 1'b0; v33 = 1'b0; r32 = '0; r33 = '0;
    for (int k = 0; k < 40; k++) begin
      bus.issue_valid = (k == 0) || (k == 16);
      bus.issue_unit  = (k == 16) ? 1'b1 : 1'b0;
      bus.issue_rd    = (k == 16) ? 5'd4 : 5'd3;
      tick();
      if (k == 32) begin v32 = obs_cv; r32 = obs_rd; end
      if (k == 33) begin v33 = obs_cv; r33 = obs_rd; end
    end
    check("arb_first_valid", v32, 1);
    check("arb_first_rd", r32, 3);
    check("arb_second_valid", v33, 1);
    check("arb_second_rd", r33, 4);
    drain();

    // Load-use and r0.
    clear_inputs();
    x_is_load = 1'b1; x_rd = 5'd12; d_rs1 = 5'd12;
    tick();
    check("lu_stall", obs_stall, 1);
    x_is_load = 1'b0;
    tick();
    check("lu_release", obs_stall, 0);
    x_is_load = 1'b1; x_rd = 5'd0; d_rs1 = 5'd0;
    tick();
    check("lu_r0_no_stall", obs_stall, 0);
    clear_inputs();
    bus.issue_valid = 1'b1; bus.issue_unit = 1'b1; bus.issue_rd = 5'd0;
    tick();
    bus.issue_valid = 1'b0;
    n_st = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (obs_stall) n_st++; end
    check("rd0_no_stall", n_st, 0);
    check("rd0_no_busy", obs_busy, 0);
    drain();

    // Bex: unit1 rd=30 blocks bex until the cycle after ack.
    clear_inputs();
    bus.wb_ack = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_unit = 1'b1; bus.issue_rd = 5'd30;
    tick();
    bus.issue_valid = 1'b0;
    d_is_bex = 1'b1;
    n_st = 0;
    for (int k = 1; k <= 20; k++) begin tick(); if (obs_stall) n_st++; end
    check("bex_stall_cycles", n_st, 16);
    clear_inputs();
    bus.issue_valid = 1'b1; bus.issue_unit = 1'b1; bus.issue_rd = 5'd30;
    tick();
    bus.issue_valid = 1'b0;
    d_rs1 = 5'd1; d_rs2 = 5'd2; d_rd = 5'd3;
    n_st = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (obs_stall) n_st++; end
    check("bex_exc_pending", obs_exc, 1);
    check("no_bex_no_stall", n_st, 0);
    drain();

    // Reset mid-RUN: unit1 rd=5, reset during cycle 4.
    clear_inputs();
    bus.issue_valid = 1'b1; bus.issue_unit = 1'b1; bus.issue_rd = 5'd5;
    tick();
    bus.issue_valid = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    mid_reset();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int u;
      clear_inputs();
      d_rs1 = pick_reg(); d_rs2 = pick_reg(); d_rd = pick_reg();
      x_rd = pick_reg();
      x_is_load = ($urandom_range(0, 3) == 0);
      d_is_bex  = ($urandom_range(0, 3) == 0);
      bus.wb_ack = ($urandom_range(0, 9) < 7);
      u = $urandom_range(0, 1);
      bus.issue_unit = 1'(u);
      if (!m_busy[u] && $urandom_range(0, 2) == 0) begin
        bus.issue_valid = 1'b1;
        bus.issue_rd = pick_reg();
      end
      if ($urandom_range(0, 499) == 0) mid_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-latency stall/bypass control.
- Tracks in-flight multicycle operations (mul, div, and future units) across N_UNITS independent channels, each with a programmable latency.
- Arbitrates their writeback and produces the stall and bubble controls for the F/D and D/X latches.
- Sits beside the decode stage. Issue comes from X, completion goes to the regfile write port, and hazard checks run against D-stage register numbers.

Parameters:
- REG_W, 5, register-number width.
- NREGS, 32, architectural register count (2**REG_W).
- N_UNITS, 2, number of multicycle units/channels (index 0 has highest writeback priority).
- LAT_W, 6, width of one latency field and of each countdown counter.
- UNIT_LATS, {6'd32,6'd16}, packed N_UNITS*LAT_W latencies. Unit i latency is field i. Each latency must be ≥2.
- EXC_REG, 30, register whose pending write blocks bex.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- issue_valid  in  1  X-stage multicycle op wants to issue
- issue_unit  in  $clog2(N_UNITS)  target unit
- issue_rd  in  REG_W  destination register
- issue_ready  out  N_UNITS  per-unit: entry IDLE
- d_rs1, d_rs2, d_rd  in  REG_W each  D-stage source and destination registers (0 = unused)
- d_is_bex  in  1  D-stage instruction is bex
- x_is_load  in  1  X-stage instruction is lw
- x_rd  in  REG_W  X-stage destination register
- complete_valid  out  1  a DONE entry is presenting a result
- complete_unit  out  $clog2(N_UNITS)  which unit
- complete_rd  out  REG_W  its destination
- wb_ack  in  1  regfile write port accepted the completion this cycle
- stall_fd  out  1  hold PC and F/D (1 = hold)
- nop_dx  out  1  load a bubble into D/X
- busy_mask  out  NREGS  bit r set when an entry with rd=r≠0 is RUN or DONE
- exc_pending  out  1  an entry targets EXC_REG
- stall_count  out  CNT_W  cycles with stall_fd=1, saturating

Behaviour:
- Each unit has one entry with state IDLE/RUN/DONE, an rd register and a LAT_W countdown.
- Reset (async, any time, including mid-operation): all entries go to IDLE, rd and counters to 0, stall_count to 0. Every output is then 0, except issue_ready, which is all ones. In-flight ops are discarded.
- Issue: the handshake fires when issue_valid is 1 and issue_ready[issue_unit] is 1. The entry goes to RUN with rd=issue_rd and cnt=LAT_i-1. If issue_valid is 1 while the unit is not ready, the request is ignored; the upstream stall guarantees this never happens, and the bench flags it as an error.
- RUN: cnt decrements each cycle. When cnt==1 at a clock edge, the entry moves to DONE. An issue in cycle 0 therefore gives DONE visible in cycle LAT_i.
- DONE: the lowest-index DONE entry drives complete_valid, complete_unit and complete_rd, held stable until wb_ack. On wb_ack, that entry goes to IDLE at the next edge.
- A unit is not ready in the same cycle it is acked; it re-issues from the next cycle.
- rd=0 entries still occupy their unit and complete normally, but never set busy_mask and never cause a hazard.
- Hazard (combinational from registered state plus D/X inputs):
  - RAW: a nonzero d_rs1 or d_rs2 is in busy_mask.
  - WAW: a nonzero d_rd is in busy_mask.
  - Load-use: x_is_load is 1, x_rd is nonzero, and x_rd equals d_rs1 or d_rs2.
  - Bex: d_is_bex is 1 and exc_pending is 1.
- When any hazard is present, stall_fd=1 and nop_dx=1.
- An entry being acked this cycle still counts as busy, so the hazard releases the cycle after writeback. No regfile write-through is relied on.
- stall_count increments on each stall_fd cycle and saturates at all ones.
- Simultaneous events: an issue to unit j and an ack of unit k≠j in the same cycle are independent. Two units finishing together: the lower index wins and the other is held.

Decomposition:
- Shared package holds:
  - entry-state enum (IDLE, RUN, DONE);
  - REG_W and NREGS constants;
  - EXC_REG constant;
  - helper function to extract latency field i from UNIT_LATS.
- Natural sub-module: scoreboard_entry, one per unit via generate (state, rd, countdown, issue/ack ports). The top holds the priority arbiter, busy_mask OR-reduction, hazard logic and stall counter.

Test Plan:
- Reset mid-RUN: issue unit1 rd=5, assert reset_n=0 at cycle 4 → issue_ready=2'b11, busy_mask=0, complete_valid=0 immediately.
- Latency: issue unit1 (LAT 16) rd=7 at cycle 0, wb_ack tied 1 → complete_valid=1 with rd=7 in cycle 16 only; busy_mask[7] clears in cycle 17.
- RAW stall: unit0 rd=9 RUN, d_rs2=9 → stall_fd=nop_dx=1 every cycle until the cycle after ack; stall_count equals that number of cycles.
- Arbitration: both units reach DONE in the same cycle (rd=3 on unit0, rd=4 on unit1), wb_ack=1 → rd=3 is presented first, rd=4 the next cycle.
- Load-use and r0: x_is_load=1, x_rd=12, d_rs1=12 → stall for 1 cycle. Repeat with x_rd=0 → no stall. An issue with rd=0 never stalls d_rs1=0.
- Bex: unit1 rd=30 RUN, d_is_bex=1 → exc_pending=1 and stall held until the cycle after ack; with the same rd=30 entry, d_is_bex=0 and no source/destination match → no stall.
